softex_tcdm_split: RTL and testbench

SOFTEX_TCDM_SPLIT -- requirements
Module: softex_tcdm_split

---
 rtl/softex_tcdm_split.sv | 143 ++++++++++++++
 tb/tb_softex_tcdm_split.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/softex_tcdm_split.sv
// Splits one wide TCDM request into MP independent 64-bit port requests and merges the responses.
// Optional stall-cycle counter enabled by defining SOFTEX_TCDM_SPLIT_STALL_CNT_EN.
module softex_tcdm_split #(
    parameter int unsigned MP          = 4,
    parameter int unsigned ADDR_STRIDE = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   in_req_i,
    output logic                   in_gnt_o,
    input  logic [31:0]            in_add_i,
    input  logic                   in_wen_i,
    input  logic [MP*8-1:0]        in_be_i,
    input  logic [MP*64-1:0]       in_data_i,
    input  logic [7:0]             in_id_i,
    input  logic                   in_r_ready_i,
    output logic                   in_r_valid_o,
    output logic [MP*64-1:0]       in_r_data_o,
    output logic [7:0]             in_r_id_o,
    output logic [MP-1:0]          out_req_o,
    input  logic [MP-1:0]          out_gnt_i,
    output logic [MP-1:0][31:0]    out_add_o,
    output logic [MP-1:0]          out_wen_o,
    output logic [MP-1:0][7:0]     out_be_o,
    output logic [MP-1:0][63:0]    out_data_o,
    output logic [MP-1:0][7:0]     out_id_o,
    output logic [MP-1:0]          out_r_ready_o,
    input  logic [MP-1:0]          out_r_valid_i,
    input  logic [MP-1:0][63:0]    out_r_data_i,
    input  logic                   stall_clr_i,
    output logic [31:0]            stall_cnt_o
);

    logic [MP-1:0]       done_q, done_d;
    logic [MP-1:0]       rvld_q, rvld_d;
    logic [MP-1:0][63:0] buf_q, buf_d;
    logic                outst_q, outst_d;
    logic [7:0]          r_id_q, r_id_d;

    logic issue_ok_s;
    logic resp_fire_s;
    logic issue_s;

    assign in_r_valid_o = outst_q & (&(rvld_q | out_r_valid_i));
    assign resp_fire_s  = in_r_valid_o & in_r_ready_i;
    assign issue_ok_s   = ~outst_q | resp_fire_s;
    // Gating with rst_ni keeps the combinational handshake quiet while reset is held.
    assign issue_s      = rst_ni & in_req_i & issue_ok_s;
    assign in_gnt_o     = issue_s & (&(done_q | out_gnt_i));
    assign out_req_o    = {MP{issue_s}} & ~done_q;
    assign in_r_id_o    = r_id_q;

    // Per-port request fields and response merge (buffered slice or live bypass).
    always_comb begin
        for (int k = 0; k < MP; k++) begin
            out_add_o[k]              = in_add_i + 32'(k * ADDR_STRIDE);
            out_be_o[k]               = in_be_i[k*8 +: 8];
            out_data_o[k]             = in_data_i[k*64 +: 64];
            out_wen_o[k]              = in_wen_i;
            out_id_o[k]               = in_id_i;
            out_r_ready_o[k]          = 1'b1;
            in_r_data_o[k*64 +: 64]   = rvld_q[k] ? buf_q[k] : out_r_data_i[k];
        end
    end

    // Next-state for grant tracking, outstanding flag and response buffers.
    always_comb begin
        done_d  = done_q;
        rvld_d  = rvld_q;
        buf_d   = buf_q;
        outst_d = outst_q;
        r_id_d  = r_id_q;
        if (in_gnt_o) begin
            done_d  = {MP{1'b0}};
            outst_d = 1'b1;
            r_id_d  = in_id_i;
        end else begin
            done_d  = done_q | (out_req_o & out_gnt_i);
            outst_d = resp_fire_s ? 1'b0 : outst_q;
        end
        if (resp_fire_s) begin
            rvld_d = {MP{1'b0}};
        end else begin
            // Late or duplicate beats are dropped: only the first beat per port is kept.
            for (int k = 0; k < MP; k++) begin
                if (outst_q && out_r_valid_i[k] && !rvld_q[k]) begin
                    rvld_d[k] = 1'b1;
                    buf_d[k]  = out_r_data_i[k];
                end else begin
                    rvld_d[k] = rvld_q[k];
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q  <= {MP{1'b0}};
            rvld_q  <= {MP{1'b0}};
            buf_q   <= {(MP*64){1'b0}};
            outst_q <= 1'b0;
            r_id_q  <= 8'd0;
        end else begin
            done_q  <= done_d;
            rvld_q  <= rvld_d;
            buf_q   <= buf_d;
            outst_q <= outst_d;
            r_id_q  <= r_id_d;
        end
    end

`ifdef SOFTEX_TCDM_SPLIT_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating stall counter; clear wins over increment.
    always_comb begin
        if (stall_clr_i) begin
            stall_cnt_d = 32'd0;
        end else if (in_req_i && !in_gnt_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    logic unused_stall_clr_s;
    assign unused_stall_clr_s = stall_clr_i;
    assign stall_cnt_o        = 32'd0;
`endif

endmodule

// File: tb/tb_softex_tcdm_split.sv
// Directed self-checking bench for softex_tcdm_split with MP=4, ADDR_STRIDE=8.
module tb_softex_tcdm_split;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic                in_req_i;
    logic                in_gnt_o;
    logic [31:0]         in_add_i;
    logic                in_wen_i;
    logic [31:0]         in_be_i;
    logic [255:0]        in_data_i;
    logic [7:0]          in_id_i;
    logic                in_r_ready_i;
    logic                in_r_valid_o;
    logic [255:0]        in_r_data_o;
    logic [7:0]          in_r_id_o;
    logic [3:0]          out_req_o;
    logic [3:0]          out_gnt_i;
    logic [3:0][31:0]    out_add_o;
    logic [3:0]          out_wen_o;
    logic [3:0][7:0]     out_be_o;
    logic [3:0][63:0]    out_data_o;
    logic [3:0][7:0]     out_id_o;
    logic [3:0]          out_r_ready_o;
    logic [3:0]          out_r_valid_i;
    logic [3:0][63:0]    out_r_data_i;
    logic                stall_clr_i;
    logic [31:0]         stall_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;

    softex_tcdm_split #(.MP(4), .ADDR_STRIDE(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_req_i(in_req_i), .in_gnt_o(in_gnt_o), .in_add_i(in_add_i), .in_wen_i(in_wen_i),
        .in_be_i(in_be_i), .in_data_i(in_data_i), .in_id_i(in_id_i),
        .in_r_ready_i(in_r_ready_i), .in_r_valid_o(in_r_valid_o), .in_r_data_o(in_r_data_o),
        .in_r_id_o(in_r_id_o),
        .out_req_o(out_req_o), .out_gnt_i(out_gnt_i), .out_add_o(out_add_o), .out_wen_o(out_wen_o),
        .out_be_o(out_be_o), .out_data_o(out_data_o), .out_id_o(out_id_o),
        .out_r_ready_o(out_r_ready_o), .out_r_valid_i(out_r_valid_i), .out_r_data_i(out_r_data_i),
        .stall_clr_i(stall_clr_i), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pat(input logic [7:0] id, input int k);
        pat = {id, 8'(k), 48'hC0DE_0000_BEEF};
    endfunction

    function automatic logic [255:0] wide(input logic [7:0] id);
        for (int k = 0; k < 4; k++) wide[k*64 +: 64] = pat(id, k);
    endfunction

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    logic [31:0] exp_stall;
    int          n_resp;

    initial begin
        rst_ni = 1'b0; in_req_i = 1'b1; in_add_i = 32'd0; in_wen_i = 1'b0; in_be_i = 32'd0;
        in_data_i = 256'd0; in_id_i = 8'd0; in_r_ready_i = 1'b1; out_gnt_i = 4'hF;
        out_r_valid_i = 4'h0; out_r_data_i = 256'd0; stall_clr_i = 1'b0;
        #13;
        check("rst_gnt", in_gnt_o, 1'b0);
        check("rst_req", out_req_o, 4'h0);
        check("rst_rvalid", in_r_valid_o, 1'b0);
        check("rst_stall", stall_cnt_o, 32'd0);
        check("rst_rid", in_r_id_o, 8'd0);

        // Single wide read, all ports grant immediately.
        step(); rst_ni = 1'b1; in_req_i = 1'b0;
        step();
        in_req_i = 1'b1; in_add_i = 32'h100; in_id_i = 8'h11; out_gnt_i = 4'hF;
        in_be_i = 32'hA1B2_C3D4; in_data_i = wide(8'h99);
        #1;
        check("t1_gnt", in_gnt_o, 1'b1);
        check("t1_req", out_req_o, 4'hF);
        check("t1_add0", out_add_o[0], 32'h100);
        check("t1_add1", out_add_o[1], 32'h108);
        check("t1_add2", out_add_o[2], 32'h110);
        check("t1_add3", out_add_o[3], 32'h118);
        check("t1_be1", out_be_o[1], 8'hC3);
        check("t1_data2", out_data_o[2], pat(8'h99, 2));
        check("t1_id", out_id_o, 32'h1111_1111);
        check("t1_wen", out_wen_o, 4'h0);
        check("t1_rready", out_r_ready_o, 4'hF);
        step();
        in_req_i = 1'b0; out_gnt_i = 4'h0; out_r_valid_i = 4'hF; out_r_data_i = wide(8'h11);
        #1;
        check("t1_rvalid", in_r_valid_o, 1'b1);
        check("t1_rdata", in_r_data_o, wide(8'h11));
        check("t1_rid", in_r_id_o, 8'h11);
        step(); out_r_valid_i = 4'h0; #1;
        check("t1_rvalid_end", in_r_valid_o, 1'b0);

        // Per-port grants: port0 @0, ports1-2 @1, port3 @3.
        step(); in_req_i = 1'b1; in_add_i = 32'h200; in_id_i = 8'h22; out_gnt_i = 4'b0001; #1;
        check("t2_req_c0", out_req_o, 4'hF);
        check("t2_gnt_c0", in_gnt_o, 1'b0);
        step(); out_gnt_i = 4'b0110; #1;
        check("t2_req_c1", out_req_o, 4'b1110);
        check("t2_gnt_c1", in_gnt_o, 1'b0);
        step(); out_gnt_i = 4'b0000; #1;
        check("t2_req_c2", out_req_o, 4'b1000);
        check("t2_gnt_c2", in_gnt_o, 1'b0);
        step(); out_gnt_i = 4'b1000; #1;
        check("t2_req_c3", out_req_o, 4'b1000);
        check("t2_gnt_c3", in_gnt_o, 1'b1);
        check("t2_add3", out_add_o[3], 32'h218);

        // Staggered responses; repeat beats on already-captured ports are dropped.
        step(); in_req_i = 1'b0; out_gnt_i = 4'h0;
        out_r_valid_i = 4'b0001; out_r_data_i = wide(8'h22); #1;
        check("t3_rv_c0", in_r_valid_o, 1'b0);
        step(); out_r_valid_i = 4'b0111; out_r_data_i = wide(8'h22);
        out_r_data_i[0] = 64'hDEAD_DEAD_DEAD_DEAD; #1;
        check("t3_rv_c1", in_r_valid_o, 1'b0);
        step(); out_r_valid_i = 4'b1000; out_r_data_i = 256'd0; out_r_data_i[3] = pat(8'h22, 3); #1;
        check("t3_rv_c2", in_r_valid_o, 1'b1);
        check("t3_rdata", in_r_data_o, wide(8'h22));
        check("t3_rid", in_r_id_o, 8'h22);
        step(); out_r_valid_i = 4'h0; #1;
        check("t3_rv_c3", in_r_valid_o, 1'b0);
        step(); out_r_valid_i = 4'hF; out_r_data_i = wide(8'hEE); #1;
        check("t3_idle_beat", in_r_valid_o, 1'b0);

        // Backpressure on the response blocks new issue.
        step(); out_r_valid_i = 4'h0;
        in_req_i = 1'b1; in_add_i = 32'h300; in_id_i = 8'h33; out_gnt_i = 4'hF; #1;
        check("t4_gnt0", in_gnt_o, 1'b1);
        step(); in_id_i = 8'h44; in_add_i = 32'h400; in_wen_i = 1'b1; in_r_ready_i = 1'b0;
        out_r_valid_i = 4'hF; out_r_data_i = wide(8'h33); #1;
        check("t4_rv_hold", in_r_valid_o, 1'b1);
        check("t4_req_hold", out_req_o, 4'h0);
        check("t4_gnt_hold", in_gnt_o, 1'b0);
        for (int c = 0; c < 4; c++) begin
            step(); out_r_valid_i = 4'h0; out_r_data_i = wide(8'h77); #1;
            check("t4_rv_hold", in_r_valid_o, 1'b1);
            check("t4_req_hold", out_req_o, 4'h0);
            check("t4_data_hold", in_r_data_o, wide(8'h33));
        end
        step(); in_r_ready_i = 1'b1; #1;
        check("t4_gnt_rel", in_gnt_o, 1'b1);
        check("t4_req_rel", out_req_o, 4'hF);
        check("t4_wen", out_wen_o, 4'hF);
        check("t4_rid_old", in_r_id_o, 8'h33);
        check("t4_data_old", in_r_data_o, wide(8'h33));
        step(); in_req_i = 1'b0; in_wen_i = 1'b0; out_gnt_i = 4'h0;
        out_r_valid_i = 4'hF; out_r_data_i = wide(8'h44); #1;
        check("t4_rv_wr", in_r_valid_o, 1'b1);
        check("t4_rid_wr", in_r_id_o, 8'h44);
        check("t4_data_wr", in_r_data_o, wide(8'h44));
        step(); out_r_valid_i = 4'h0; #1;
        check("t4_rv_end", in_r_valid_o, 1'b0);

        // Stall counter: clear, 7 stalled cycles, clear again.
        step(); stall_clr_i = 1'b1;
        step(); stall_clr_i = 1'b0; in_req_i = 1'b1; in_add_i = 32'h500; out_gnt_i = 4'h0;
        for (int c = 0; c < 7; c++) step();
        in_req_i = 1'b0; #1;
`ifdef SOFTEX_TCDM_SPLIT_STALL_CNT_EN
        exp_stall = 32'd7;
`else
        exp_stall = 32'd0;
`endif
        check("stall_7", stall_cnt_o, exp_stall);
        stall_clr_i = 1'b1;
        step(); stall_clr_i = 1'b0; #1;
        check("stall_clr", stall_cnt_o, 32'd0);

        // 16 back-to-back reads, one response per cycle.
        n_resp = 0;
        for (int i = 0; i <= 16; i++) begin
            step();
            in_req_i = (i < 16); out_gnt_i = (i < 16) ? 4'hF : 4'h0;
            in_id_i = 8'(i); in_add_i = 32'(i) << 5;
            out_r_valid_i = (i > 0) ? 4'hF : 4'h0; out_r_data_i = wide(8'(i - 1));
            #1;
            if (i < 16) check("b2b_gnt", in_gnt_o, 1'b1);
            if (i > 0) begin
                check("b2b_rv", in_r_valid_o, 1'b1);
                check("b2b_rid", in_r_id_o, 8'(i - 1));
                if (in_r_valid_o) n_resp++;
            end
        end
        check("b2b_count", n_resp, 16);
        step(); out_r_valid_i = 4'h0; #1;
        check("b2b_rv_end", in_r_valid_o, 1'b0);

        // Reset in the middle of a transaction discards it.
        step(); in_req_i = 1'b1; in_id_i = 8'h55; out_gnt_i = 4'hF;
        step(); in_req_i = 1'b0; out_r_valid_i = 4'b0001; out_r_data_i = wide(8'h55);
        step(); rst_ni = 1'b0; in_req_i = 1'b1; out_r_valid_i = 4'h0; #1;
        check("mrst_gnt", in_gnt_o, 1'b0);
        check("mrst_req", out_req_o, 4'h0);
        check("mrst_rv", in_r_valid_o, 1'b0);
        check("mrst_rid", in_r_id_o, 8'd0);
        check("mrst_stall", stall_cnt_o, 32'd0);
        step(); rst_ni = 1'b1; in_req_i = 1'b0; out_r_valid_i = 4'b1110; #1;
        check("mrst_rv1", in_r_valid_o, 1'b0);
        step(); out_r_valid_i = 4'hF; #1;
        check("mrst_rv2", in_r_valid_o, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
